// File: rtl/motor_pkg.sv
// Shared motor-path types: quadrature state encoding and the one-step
// quadrature sequencer used by the encoder emulator.
package motor_pkg;

  // Encoded so that bit 1 is channel A and bit 0 is channel B.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_state_t;

  // Forward walks 00->10->11->01->00; reverse walks the same ring backwards.
  function automatic quad_state_t quad_next(input quad_state_t state, input logic dir);
    quad_state_t nxt;
    nxt = Q00;
    if (dir == 1'b0) begin
      case (state)
        Q00:     nxt = Q10;
        Q10:     nxt = Q11;
        Q11:     nxt = Q01;
        Q01:     nxt = Q00;
        default: nxt = Q00;
      endcase
    end else begin
      case (state)
        Q00:     nxt = Q01;
        Q01:     nxt = Q11;
        Q11:     nxt = Q10;
        Q10:     nxt = Q00;
        default: nxt = Q00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/quad_encoder_emulator_edge_timer.sv
// Edge period counter: emits a one-cycle tick every 'period' clocks while
// enabled. The period is compared live so a shrink past the count ticks at once.
module edge_timer #(
  parameter int K_PERW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [K_PERW-1:0] period,
  output logic              tick
);

  localparam logic [K_PERW-1:0] PER_ZERO = {K_PERW{1'b0}};
  localparam logic [K_PERW-1:0] PER_ONE  = {{(K_PERW-1){1'b0}}, 1'b1};

  logic [K_PERW-1:0] cnt_r;
  logic [K_PERW-1:0] cnt_next_s;
  logic              run_s;
  logic              tick_s;

  assign run_s  = enable && (period != PER_ZERO);
  assign tick_s = run_s && (cnt_r >= (period - PER_ONE));
  assign tick   = tick_s;

  // Next count: cleared while idle so a restart waits a full period.
  always_comb begin
    cnt_next_s = cnt_r;
    if (!run_s) begin
      cnt_next_s = PER_ZERO;
    end else if (tick_s) begin
      cnt_next_s = PER_ZERO;
    end else begin
      cnt_next_s = cnt_r + PER_ONE;
    end
  end

  // Period counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= PER_ZERO;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: A/B/I generation from a commanded edge period,
// direction and counts-per-revolution. Index output built only with QENC_EMU_INDEX_EN.
module quad_encoder_emulator
  import motor_pkg::*;
#(
  parameter int K_PERW = 16,
  parameter int K_POSW = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_dir,
  input  logic [K_PERW-1:0] i_period,
  input  logic [K_POSW-1:0] i_cpr,
  output logic              o_enc_a,
  output logic              o_enc_b,
  output logic              o_enc_i,
  output logic              o_step,
  output logic [K_POSW-1:0] o_pos
);

  localparam logic [K_POSW-1:0] POS_ZERO = {K_POSW{1'b0}};
  localparam logic [K_POSW-1:0] POS_ONE  = {{(K_POSW-1){1'b0}}, 1'b1};
  localparam logic [K_POSW:0]   EXT_ONE  = {{K_POSW{1'b0}}, 1'b1};
  localparam logic [K_POSW:0]   CPR_FULL = {1'b1, {K_POSW{1'b0}}};

  logic              tick_s;
  quad_state_t       state_r;
  logic [K_POSW-1:0] pos_r;
  logic [K_POSW-1:0] pos_next_s;
  logic              step_r;
  logic [K_POSW:0]   cpr_ext_s;
  logic [K_POSW:0]   cpr_m1_s;
  logic [K_POSW:0]   pos_ext_s;

  edge_timer #(
    .K_PERW (K_PERW)
  ) u_edge_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .enable (i_enable),
    .period (i_period),
    .tick   (tick_s)
  );

  // One extra bit lets a zero cpr stand for a full 2**K_POSW revolution.
  assign cpr_ext_s = (i_cpr == POS_ZERO) ? CPR_FULL : {1'b0, i_cpr};
  assign cpr_m1_s  = cpr_ext_s - EXT_ONE;
  assign pos_ext_s = {1'b0, pos_r};

  // Next position with wrap; an out-of-range position snaps to the wrap target.
  always_comb begin
    pos_next_s = pos_r;
    if (i_dir == 1'b0) begin
      if ((pos_ext_s + EXT_ONE) >= cpr_ext_s) begin
        pos_next_s = POS_ZERO;
      end else begin
        pos_next_s = pos_r + POS_ONE;
      end
    end else begin
      if ((pos_r == POS_ZERO) || (pos_ext_s >= cpr_ext_s)) begin
        pos_next_s = cpr_m1_s[K_POSW-1:0];
      end else begin
        pos_next_s = pos_r - POS_ONE;
      end
    end
  end

  // Quadrature state, position and step pulse advance together on a tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= Q00;
      pos_r   <= POS_ZERO;
      step_r  <= 1'b0;
    end else if (tick_s) begin
      state_r <= quad_next(state_r, i_dir);
      pos_r   <= pos_next_s;
      step_r  <= 1'b1;
    end else begin
      state_r <= state_r;
      pos_r   <= pos_r;
      step_r  <= 1'b0;
    end
  end

`ifdef QENC_EMU_INDEX_EN
  logic idx_r;

  // Index is high for the whole quadrature state that sits at position zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_r <= 1'b1;
    end else if (tick_s) begin
      idx_r <= (pos_next_s == POS_ZERO);
    end else begin
      idx_r <= idx_r;
    end
  end

  assign o_enc_i = idx_r;
`else
  assign o_enc_i = 1'b0;
`endif

  assign o_enc_a = state_r[1];
  assign o_enc_b = state_r[0];
  assign o_step  = step_r;
  assign o_pos   = pos_r;

endmodule
